prog_loader: RTL

- Hardware loader/unloader for the CPU's instruction and data RAMs.
- Accepts a byte-stream frame from a host link (UART or JTAG bridge, valid/ready):
  - writes machine code into IRAM and initial data into DRAM;
  - pulses the CPU start and waits for idle;
  - streams DRAM contents back out as bytes.
- Sits between the host link and the IRAM/DRAM write ports; mem_own steers the RAM port muxes.

---
 rtl/prog_loader_if.sv | 35 +++
 rtl/prog_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - Host byte link, IRAM/DRAM port and CPU control bundle of the program loader
interface prog_loader_if #(
    parameter int W_ADDR  = 8,
    parameter int W_INSTR = 16
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               iram_write;
    logic [W_ADDR-1:0]  iram_addr;
    logic [W_INSTR-1:0] iram_din;
    logic               dram_write;
    logic [W_ADDR-1:0]  dram_addr;
    logic [7:0]         dram_din;
    logic [7:0]         dram_dout;
    logic               cpu_start;
    logic               cpu_idle;
    logic               mem_own;
    logic               busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, dram_dout, cpu_idle,
        output rx_ready, tx_data, tx_valid, iram_write, iram_addr, iram_din,
               dram_write, dram_addr, dram_din, cpu_start, mem_own, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dram_dout, cpu_idle,
        input  rx_ready, tx_data, tx_valid, iram_write, iram_addr, iram_din,
               dram_write, dram_addr, dram_din, cpu_start, mem_own, busy
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - Loads IRAM/DRAM from a host byte frame, starts the CPU and streams DRAM back
module prog_loader #(
    parameter int W_ADDR     = 8,
    parameter int W_INSTR    = 16,
    parameter int DUMP_DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, I_LO, I_HI, D_LEN, D_DATA, START, RUN, DUMP_RD, DUMP_TX
    } state_t;

    localparam logic [W_ADDR:0] DUMP_LAST = (W_ADDR+1)'(DUMP_DEPTH - 1);

    state_t             state, state_nx;
    logic [W_ADDR:0]    cnt, cnt_inc;
    logic [7:0]         len_l, len_d, lo_byte, tx_hold;
    logic               rx_ready, rx_hs, tx_valid, tx_hs, tx_first, armed;
    logic               write_pending;
    logic               iram_write, dram_write, cpu_start, mem_own;
    logic [W_ADDR-1:0]  iram_addr, dram_addr;
    logic [W_INSTR-1:0] iram_din;
    logic [7:0]         dram_din;

    assign cnt_inc       = cnt + 1'b1;
    assign rx_ready      = !rst && (state inside {IDLE, I_LO, I_HI, D_LEN, D_DATA});
    assign tx_valid      = (state == DUMP_TX);
    assign rx_hs         = bus.rx_valid && rx_ready;
    assign tx_hs         = tx_valid && bus.tx_ready;
    assign write_pending = iram_write || dram_write;

    assign bus.rx_ready   = rx_ready;
    assign bus.tx_valid   = tx_valid;
    // RAM data appears one cycle after the address, so the first DUMP_TX cycle forwards it directly
    assign bus.tx_data    = tx_first ? bus.dram_dout : tx_hold;
    assign bus.iram_write = iram_write;
    assign bus.iram_addr  = iram_addr;
    assign bus.iram_din   = iram_din;
    assign bus.dram_write = dram_write;
    assign bus.dram_addr  = dram_addr;
    assign bus.dram_din   = dram_din;
    assign bus.cpu_start  = cpu_start;
    assign bus.mem_own    = mem_own;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_hs) state_nx = I_LO;
            I_LO:    if (rx_hs) state_nx = I_HI;
            I_HI:    if (rx_hs) state_nx = (cnt == (W_ADDR+1)'(len_l)) ? D_LEN : I_LO;
            D_LEN:   if (rx_hs) state_nx = (bus.rx_data == 8'd0) ? START : D_DATA;
            D_DATA:  if (rx_hs && cnt_inc == (W_ADDR+1)'(len_d)) state_nx = START;
            START:   if (!write_pending) state_nx = RUN;
            RUN:     if (armed && bus.cpu_idle) state_nx = DUMP_RD;
            DUMP_RD: state_nx = DUMP_TX;
            DUMP_TX: if (tx_hs) state_nx = (cnt == DUMP_LAST) ? IDLE : DUMP_RD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            len_l      <= '0;
            len_d      <= '0;
            lo_byte    <= '0;
            tx_hold    <= '0;
            tx_first   <= 1'b0;
            armed      <= 1'b0;
            iram_write <= 1'b0;
            iram_addr  <= '0;
            iram_din   <= '0;
            dram_write <= 1'b0;
            dram_addr  <= '0;
            dram_din   <= '0;
            cpu_start  <= 1'b0;
            mem_own    <= 1'b1;
        end else begin
            iram_write <= 1'b0;
            dram_write <= 1'b0;
            cpu_start  <= 1'b0;
            tx_first   <= 1'b0;
            // idle is only trusted from the second cycle after the start pulse onwards
            armed      <= (state == RUN) && !cpu_start;
            case (state)
                IDLE: if (rx_hs) begin
                    len_l <= bus.rx_data;
                    cnt   <= '0;
                end
                I_LO: if (rx_hs) lo_byte <= bus.rx_data;
                I_HI: if (rx_hs) begin
                    iram_write <= 1'b1;
                    iram_addr  <= cnt[W_ADDR-1:0];
                    iram_din   <= W_INSTR'({bus.rx_data, lo_byte});
                    cnt        <= cnt_inc;
                end
                D_LEN: if (rx_hs) begin
                    len_d <= bus.rx_data;
                    cnt   <= '0;
                end
                D_DATA: if (rx_hs) begin
                    dram_write <= 1'b1;
                    dram_addr  <= cnt[W_ADDR-1:0];
                    dram_din   <= bus.rx_data;
                    cnt        <= cnt_inc;
                end
                START: if (!write_pending) begin
                    cpu_start <= 1'b1;
                    mem_own   <= 1'b0;
                end
                RUN: if (state_nx == DUMP_RD) begin
                    mem_own   <= 1'b1;
                    cnt       <= '0;
                    dram_addr <= '0;
                end
                DUMP_RD: tx_first <= 1'b1;
                DUMP_TX: begin
                    if (tx_first) tx_hold <= bus.dram_dout;
                    if (tx_hs && cnt != DUMP_LAST) begin
                        cnt       <= cnt_inc;
                        dram_addr <= cnt_inc[W_ADDR-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
